// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage, with
// operand and result skew registers so the full sum word leaves aligned, under valid/ready flow.
module cla_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NG = WIDTH / GROUP;

  // One lookahead group: every internal carry is a flat sum of products of g, p and the
  // group carry-in, so no carry ripples through the group.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] x,
                                               input logic [GROUP-1:0] y,
                                               input logic             ci);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             term;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(GROUP); i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // Stage k keeps the full operand words (upper groups still pending), the sum word with
  // groups 0..k filled in, and its group carry-out.
  logic [WIDTH-1:0] a_q   [NG];
  logic [WIDTH-1:0] be_q  [NG];
  logic [WIDTH-1:0] sum_q [NG];
  logic             c_q   [NG];
  logic             v_q   [NG];

  logic [WIDTH-1:0] a_d   [NG];
  logic [WIDTH-1:0] be_d  [NG];
  logic [WIDTH-1:0] sum_d [NG];
  logic             c_d   [NG];
  logic             v_d   [NG];
  logic             cin_s [NG];
  logic [GROUP:0]   grp   [NG];

  logic advance;

  assign advance  = !v_q[NG-1] || out_ready;
  assign in_ready = advance;

  always_comb begin
    a_d[0]   = a;
    be_d[0]  = sub ? ~b : b;
    cin_s[0] = sub ? 1'b1 : cin;
    sum_d[0] = '0;
    v_d[0]   = in_valid;
    for (int k = 1; k < int'(NG); k++) begin
      a_d[k]   = a_q[k-1];
      be_d[k]  = be_q[k-1];
      cin_s[k] = c_q[k-1];
      sum_d[k] = sum_q[k-1];
      v_d[k]   = v_q[k-1];
    end
    for (int k = 0; k < int'(NG); k++) begin
      grp[k] = cla_group(a_d[k][k*GROUP +: GROUP], be_d[k][k*GROUP +: GROUP], cin_s[k]);
      sum_d[k][k*GROUP +: GROUP] = grp[k][GROUP-1:0];
      c_d[k] = grp[k][GROUP];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NG); k++) begin
        a_q[k]   <= '0;
        be_q[k]  <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < int'(NG); k++) begin
        a_q[k]   <= a_d[k];
        be_q[k]  <= be_d[k];
        sum_q[k] <= sum_d[k];
        c_q[k]   <= c_d[k];
        v_q[k]   <= v_d[k];
      end
    end
  end

  assign out_valid = v_q[NG-1];
  assign sum       = sum_q[NG-1];
  assign cout      = c_q[NG-1];
  assign ovf       = (a_q[NG-1][WIDTH-1] == be_q[NG-1][WIDTH-1]) &&
                     (sum_q[NG-1][WIDTH-1] != a_q[NG-1][WIDTH-1]);

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed corner cases, random streaming and
// back-pressure against a plain-arithmetic reference model, plus asynchronous reset.
module tb_cla_adder_pipe;

  localparam int W  = 16;
  localparam int G  = 4;
  localparam int NG = W / G;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  cla_adder_pipe #(.WIDTH(W), .GROUP(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          n0;
  bit          chk_lat;
  bit          stalled_prev;
  logic [17:0] held;
  logic [17:0] last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: signed/unsigned arithmetic on plain integers.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    exp_t m;
    int   ua, ub, sa, sb, r;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    if (s) begin
      r   = sa - sb;
      m.s = 16'(ua - ub);
      m.c = (ua >= ub);
    end else begin
      r   = sa + sb + int'(ci);
      m.s = 16'(ua + ub + int'(ci));
      m.c = (ua + ub + int'(ci)) > 65535;
    end
    m.o   = (r > 32767) || (r < -32768);
    m.cyc = 0;
    return m;
  endfunction

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic s, input logic v);
    a        = av;
    b        = bv;
    cin      = ci;
    sub      = s;
    in_valid = v;
  endtask

  task automatic drive_rand(input logic v);
    drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), v);
  endtask

  // One clock: inputs are already set just after a falling edge; observe, then advance.
  task automatic tick();
    exp_t e;
    #1;
    if (stalled_prev) check("hold", {14'd0, sum, cout, ovf}, {14'd0, held});
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("result", {14'd0, sum, cout, ovf}, {14'd0, e.s, e.c, e.o});
        if (chk_lat) check("latency", cyc - e.cyc, NG);
        last = {sum, cout, ovf};
      end
    end
    if (in_valid && in_ready) begin
      e     = model(a, b, cin, sub);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    stalled_prev = out_valid && !out_ready;
    held         = {sum, cout, ovf};
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    out_ready    = 1'b0;
    chk_lat      = 1'b0;
    stalled_prev = 1'b0;
    held         = '0;
    last         = '0;
    drive('0, '0, 1'b0, 1'b0, 1'b0);

    // Reset
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_sum", sum, 16'h0000);
    check("post_rst_cout", cout, 1'b0);
    check("post_rst_ovf", ovf, 1'b0);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    cyc++;

    // Full-width carry and signed overflow
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick();
    drain();
    check("carry_sum", last[17:2], 16'h0000);
    check("carry_cout", last[1], 1'b1);
    check("carry_ovf", last[0], 1'b0);
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick();
    drain();
    check("ovf_sum", last[17:2], 16'h8000);
    check("ovf_cout", last[1], 1'b0);
    check("ovf_ovf", last[0], 1'b1);

    // Subtract (cin ignored)
    drive(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
    tick();
    drain();
    check("sub1_sum", last[17:2], 16'h7FFF);
    check("sub1_cout", last[1], 1'b1);
    check("sub1_ovf", last[0], 1'b1);
    drive(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1);
    tick();
    drain();
    check("sub2_sum", last[17:2], 16'hFFFE);
    check("sub2_cout", last[1], 1'b0);
    check("sub2_ovf", last[0], 1'b0);

    // Streaming: 200 back-to-back beats
    n0 = n_out;
    for (int i = 0; i < 200; i++) begin
      drive_rand(1'b1);
      tick();
    end
    check("stream_outputs", n_out - n0, 200 - NG);
    drain();

    // Back-pressure with a full pipeline
    for (int i = 0; i < 6; i++) begin
      drive_rand(1'b1);
      tick();
    end
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b1);
      tick();
    end
    drain();

    // Random in_valid / out_ready toggling
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Asynchronous reset with beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_rand(1'b1);
      tick();
    end
    check("pre_areset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 1'b0);
    check("areset_in_ready", in_ready, 1'b1);
    check("areset_sum", sum, 16'h0000);
    exp_q.delete();
    stalled_prev = 1'b0;
    @(negedge clk);
    cyc++;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    last      = '1;
    drive(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    tick();
    drain();
    check("after_reset_sum", last[17:2], 16'h5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
